rst_seq_ctrl: RTL and testbench
===============================

// Module: rst_seq_ctrl
// PURPOSE
//  Parametrised reset sequencer for riscv_top and its sim harness. Replaces a fixed "hold reset N cycles" scheme.
//  Holds NCH downstream reset channels for HOLD_CYCLES, then releases them in order (0 first), STAGGER cycles apart.
//  Also accepts a synchronous soft-reset request (button/host) and an optional run-time watchdog.
// PARAMETERS
//  NCH            4        number of reset channels (>=1)
//  HOLD_CYCLES    25       rising edges all channels stay asserted after reset/request ends (>=1)
//  STAGGER        2        edges between successive channel releases (0 = all release together)
//  TIMEOUT_CYCLES 1048576  watchdog limit: RUN-state edges without a kick (>=2)
//  WDOG_AUTO_RST  0        1 = watchdog timeout re-enters HOLD (full re-sequence); 0 = flag only
// PORTS
//  clk           in   1    single clock
//  rst_n         in   1    asynchronous, active-low reset
//  sw_rst_req    in   1    synchronous soft-reset request, level, clk domain
//  wdog_kick     in   1    watchdog restart strobe, 1 cycle
//  ch_rst        out  NCH  per-channel reset, active-high, registered
//  rst_done      out  1    all channels released (state RUN)
//  wdog_timeout  out  1    sticky timeout flag
//  seq_state     out  2    current state (package encoding), debug
// BEHAVIOUR
//  Reset (rst_n=0, async): ch_rst='1, rst_done=0, wdog_timeout=0, state=HOLD, all counters 0.
//  States: HOLD=0, RELEASE=1, RUN=2 (3 reserved; it decodes to HOLD).
//  HOLD: hold_cnt increments each edge while sw_rst_req=0.
//    - At the edge where hold_cnt reaches HOLD_CYCLES, ch_rst[0] deasserts. That is edge #HOLD_CYCLES after rst_n rises.
//    - Then go to RELEASE with idx=1, or straight to RUN if NCH==1 or STAGGER==0 (all ch_rst drop on that same edge).
//  RELEASE: ch_rst[idx] deasserts STAGGER edges after ch_rst[idx-1].
//    - rst_done rises on the same edge that ch_rst[NCH-1] falls; state=RUN.
//    - Deasserted channels never re-assert except via sw_rst_req, rst_n or auto-reset.
//  RUN: ch_rst='0, rst_done=1.
//  sw_rst_req=1 in any state:
//    - Next edge: ch_rst='1, rst_done=0, state=HOLD, hold_cnt=0.
//    - hold_cnt stays 0 while the request is held. Counting restarts on the first edge with sw_rst_req=0.
//  Counter widths: $clog2(max+1). No wrap is possible; counters saturate at their limit and stop.
//  Latency: output changes are registered, 1 edge after the deciding condition.
// CONFIGURATION
//  Macro RST_SEQ_WDOG_EN.
//  Defined:
//    - wdog_cnt counts RUN-state edges and is cleared outside RUN and on wdog_kick.
//    - When wdog_cnt reaches TIMEOUT_CYCLES, wdog_timeout sets (sticky). It clears only on rst_n or on entry to HOLD.
//    - If WDOG_AUTO_RST=1, the same edge also enters HOLD (ch_rst='1). wdog_timeout stays 1 through the re-sequence until the next HOLD entry.
//    - wdog_kick on the limit edge wins: counter clears, no timeout.
//  Undefined: no watchdog logic; wdog_timeout tied 0; wdog_kick ignored; WDOG_AUTO_RST has no effect.
// STRUCTURE
//  rst_seq_pkg:
//    - seq_state_t enum (HOLD/RELEASE/RUN)
//    - localparam SEQ_STATE_W=2
//    - function cnt_w(max) returning $clog2(max+1)
//  Sub-module rst_seq_wdog: watchdog counter and sticky flag, instantiated only under RST_SEQ_WDOG_EN.
//  Top level: FSM, hold/stagger counters, ch_rst register.
// TESTING  (NCH=4, HOLD_CYCLES=25, STAGGER=2, TIMEOUT_CYCLES=100, macro defined unless noted)
//  1. rst_n low 3 edges then high.
//     -> ch_rst=4'hF for edges 1..24; edge 25 ch_rst=4'hE; 27 4'hC; 29 4'h8; 31 4'h0 with rst_done=1.
//  2. sw_rst_req pulsed 1 cycle at edge 28.
//     -> edge 29 ch_rst=4'hF, rst_done=0; channel 0 releases 25 edges after the request drops.
//  3. In RUN, no kicks.
//     -> wdog_timeout=1 at RUN edge 100 and stays 1.
//     -> With WDOG_AUTO_RST=1: same edge ch_rst=4'hF, then the full sequence of test 1 repeats.
//  4. In RUN, wdog_kick every 99 edges, including one kick exactly on edge 100 -> wdog_timeout never sets.
//  5. STAGGER=0, NCH=1 variants -> ch_rst drops fully at edge 25, rst_done same edge.
//     -> rst_n asserted mid-RELEASE: outputs return to reset values immediately, without waiting for a clock edge.
//  6. Macro undefined, 300 RUN edges without kicks -> wdog_timeout=0, ch_rst=0 throughout.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Purpose : shared types and helpers for the reset sequencer (state encoding, counter sizing).
// Latency : n/a (package only).
// Backpressure: n/a.
package rst_seq_pkg;

  localparam int SEQ_STATE_W = 2;

  // Encoding 3 is reserved and behaves as HOLD.
  typedef enum logic [SEQ_STATE_W-1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } seq_state_t;

  // Bits needed to hold 0..max. Floored at 1 so a zero limit still yields a legal vector.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/rst_seq_wdog.sv
// Purpose : run-time watchdog; counts RUN-state edges, raises a sticky timeout at the limit.
// Latency : flag registered, set on the edge where the count reaches TIMEOUT_CYCLES.
// Backpressure: none; a kick on the limit edge wins and clears the count.
// Ports: clk, rst_n (async active-low), in_run, hold_entry (soft reset, clears flag),
//        wdog_kick, wdog_timeout (sticky), timeout_evt (combinational, limit reached this edge).
module rst_seq_wdog
  import rst_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_run,
  input  logic hold_entry,
  input  logic wdog_kick,
  output logic wdog_timeout,
  output logic timeout_evt
);

  localparam int W = cnt_w(TIMEOUT_CYCLES);

  logic [W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic         timeout_q, timeout_d;

  always_comb begin
    wdog_cnt_d  = wdog_cnt_q;
    timeout_d   = timeout_q;
    timeout_evt = 1'b0;
    if (hold_entry) begin
      wdog_cnt_d = '0;
      timeout_d  = 1'b0;
    end else if (!in_run || wdog_kick) begin
      wdog_cnt_d = '0;
    end else if (wdog_cnt_q != W'(TIMEOUT_CYCLES)) begin
      // Saturates at the limit; once reached the flag is already set.
      wdog_cnt_d = wdog_cnt_q + 1'b1;
      if (wdog_cnt_q == W'(TIMEOUT_CYCLES - 1)) begin
        timeout_d   = 1'b1;
        timeout_evt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign wdog_timeout = timeout_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Purpose : reset sequencer; holds NCH channel resets HOLD_CYCLES edges, then releases 0..NCH-1 STAGGER apart.
// Latency : all outputs registered, one edge after the deciding condition.
// Backpressure: none; sw_rst_req (level) restarts the sequence from HOLD on the next edge.
// Ports: clk, rst_n (async active-low), sw_rst_req, wdog_kick, ch_rst[NCH] (active-high),
//        rst_done, wdog_timeout (sticky), seq_state (debug).
// Build option: define RST_SEQ_WDOG_EN to include the watchdog (rst_seq_wdog); otherwise
//        wdog_timeout is tied 0 and wdog_kick / WDOG_AUTO_RST are ignored.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NCH            = 4,
  parameter int HOLD_CYCLES    = 25,
  parameter int STAGGER        = 2,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int WDOG_AUTO_RST  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_rst_req,
  input  logic                   wdog_kick,
  output logic [NCH-1:0]         ch_rst,
  output logic                   rst_done,
  output logic                   wdog_timeout,
  output logic [SEQ_STATE_W-1:0] seq_state
);

  localparam int HOLD_W   = cnt_w(HOLD_CYCLES);
  localparam int STG_W    = cnt_w(STAGGER);
  localparam int IDX_W    = cnt_w(NCH);
  localparam int STG_LAST = (STAGGER > 0) ? STAGGER - 1 : 0;
  localparam bit ONE_SHOT = (NCH == 1) || (STAGGER == 0);

  seq_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [STG_W-1:0]  stg_cnt_q, stg_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NCH-1:0]    ch_rst_q, ch_rst_d;
  logic              rst_done_q, rst_done_d;
  logic              wdog_restart;

`ifdef RST_SEQ_WDOG_EN
  logic timeout_evt;

  rst_seq_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_run       (state_q == RUN),
    .hold_entry   (sw_rst_req),
    .wdog_kick    (wdog_kick),
    .wdog_timeout (wdog_timeout),
    .timeout_evt  (timeout_evt)
  );

  assign wdog_restart = timeout_evt && (WDOG_AUTO_RST != 0);
`else
  logic unused_wdog;
  assign unused_wdog  = wdog_kick & (WDOG_AUTO_RST != 0) & (TIMEOUT_CYCLES > 0);
  assign wdog_timeout = 1'b0;
  assign wdog_restart = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    stg_cnt_d  = stg_cnt_q;
    idx_d      = idx_q;
    ch_rst_d   = ch_rst_q;
    rst_done_d = rst_done_q;
    if (sw_rst_req || wdog_restart) begin
      state_d    = HOLD;
      hold_cnt_d = '0;
      stg_cnt_d  = '0;
      idx_d      = '0;
      ch_rst_d   = '1;
      rst_done_d = 1'b0;
    end else begin
      case (state_q)
        RELEASE: begin
          if (stg_cnt_q == STG_W'(STG_LAST)) begin
            stg_cnt_d = '0;
            ch_rst_d  = ch_rst_q & ~(NCH'(1) << idx_q);
            if (idx_q == IDX_W'(NCH - 1)) begin
              state_d    = RUN;
              ch_rst_d   = '0;
              rst_done_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            stg_cnt_d = stg_cnt_q + 1'b1;
          end
        end
        RUN: begin
          ch_rst_d   = '0;
          rst_done_d = 1'b1;
        end
        default: begin  // HOLD and the reserved encoding
          if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
            hold_cnt_d = HOLD_W'(HOLD_CYCLES);
            if (ONE_SHOT) begin
              state_d    = RUN;
              ch_rst_d   = '0;
              rst_done_d = 1'b1;
            end else begin
              state_d   = RELEASE;
              idx_d     = IDX_W'(1);
              stg_cnt_d = '0;
              ch_rst_d  = ~NCH'(1);
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      stg_cnt_q  <= '0;
      idx_q      <= '0;
      ch_rst_q   <= '1;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      stg_cnt_q  <= stg_cnt_d;
      idx_q      <= idx_d;
      ch_rst_q   <= ch_rst_d;
      rst_done_q <= rst_done_d;
    end
  end

  assign ch_rst    = ch_rst_q;
  assign rst_done  = rst_done_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: main instance (NCH=4, STAGGER=2), an auto-reset
// watchdog instance, a STAGGER=0 instance and an NCH=1 instance share clk/rst_n.
module tb_rst_seq_ctrl;

`ifdef RST_SEQ_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, sw, kick;
  logic [3:0] ch_a, ch_b, ch_c;
  logic [0:0] ch_d;
  logic       done_a, done_b, done_c, done_d;
  logic       to_a, to_b, to_c, to_d;
  logic [1:0] st_a, st_b, st_c, st_d;

  rst_seq_ctrl #(.NCH(4), .HOLD_CYCLES(25), .STAGGER(2), .TIMEOUT_CYCLES(100), .WDOG_AUTO_RST(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw), .wdog_kick(kick),
    .ch_rst(ch_a), .rst_done(done_a), .wdog_timeout(to_a), .seq_state(st_a));
  rst_seq_ctrl #(.NCH(4), .HOLD_CYCLES(25), .STAGGER(2), .TIMEOUT_CYCLES(100), .WDOG_AUTO_RST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(1'b0), .wdog_kick(1'b0),
    .ch_rst(ch_b), .rst_done(done_b), .wdog_timeout(to_b), .seq_state(st_b));
  rst_seq_ctrl #(.NCH(4), .HOLD_CYCLES(25), .STAGGER(0), .TIMEOUT_CYCLES(100), .WDOG_AUTO_RST(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(1'b0), .wdog_kick(1'b0),
    .ch_rst(ch_c), .rst_done(done_c), .wdog_timeout(to_c), .seq_state(st_c));
  rst_seq_ctrl #(.NCH(1), .HOLD_CYCLES(25), .STAGGER(2), .TIMEOUT_CYCLES(100), .WDOG_AUTO_RST(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(1'b0), .wdog_kick(1'b0),
    .ch_rst(ch_d), .rst_done(done_d), .wdog_timeout(to_d), .seq_state(st_d));

  int n_vec = 0;
  int n_err = 0;
  int e     = 0;  // edges since the last rst_n release

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    e++;
  endtask

  initial begin
    rst_n = 1'b0; sw = 1'b0; kick = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ch", ch_a, 4'hF);
    chk("rst_done", done_a, 0);
    chk("rst_wdog", to_a, 0);
    chk("rst_state", st_a, 0);
    chk("rst_ch_d", ch_d, 1);
    rst_n = 1'b1;
    e = 0;

    // Hold phase and staggered release
    while (e < 24) begin
      tick;
      chk("hold_ch", ch_a, 4'hF);
      chk("hold_done", done_a, 0);
    end
    chk("s0_hold_ch", ch_c, 4'hF);
    chk("n1_hold_ch", ch_d, 1);
    tick; // 25
    chk("rel0_ch", ch_a, 4'hE);
    chk("rel0_state", st_a, 1);
    chk("s0_ch", ch_c, 4'h0);
    chk("s0_done", done_c, 1);
    chk("s0_state", st_c, 2);
    chk("n1_ch", ch_d, 0);
    chk("n1_done", done_d, 1);
    tick; chk("e26_ch", ch_a, 4'hE);
    tick; chk("e27_ch", ch_a, 4'hC);
    tick; chk("e28_ch", ch_a, 4'hC);
    tick; chk("e29_ch", ch_a, 4'h8);
    tick; chk("e30_ch", ch_a, 4'h8);
    chk("e30_done", done_a, 0);
    tick; // 31
    chk("e31_ch", ch_a, 4'h0);
    chk("e31_done", done_a, 1);
    chk("e31_state", st_a, 2);

    // RUN: main kicked at edges 130 and 230 (the latter is exactly the limit edge)
    while (e < 340) begin
      if (e == 129 || e == 229) kick = 1'b1;
      tick;
      kick = 1'b0;
      chk("run_ch", ch_a, 4'h0);
      chk("run_wdog", to_a, WD && (e >= 330));
      if (e == 130) begin
        chk("auto_pre_ch", ch_b, 4'h0);
        chk("auto_pre_to", to_b, 0);
      end
      if (e == 131) begin
        chk("auto_to", to_b, WD);
        chk("auto_ch", ch_b, WD ? 4'hF : 4'h0);
        chk("auto_state", st_b, WD ? 0 : 2);
      end
      if (e == 155) chk("auto_e155", ch_b, WD ? 4'hF : 4'h0);
      if (e == 156) chk("auto_e156", ch_b, WD ? 4'hE : 4'h0);
      if (e == 158) chk("auto_e158", ch_b, WD ? 4'hC : 4'h0);
      if (e == 160) chk("auto_e160", ch_b, WD ? 4'h8 : 4'h0);
      if (e == 162) begin
        chk("auto_e162_ch", ch_b, 4'h0);
        chk("auto_e162_done", done_b, 1);
        chk("auto_e162_to", to_b, WD);
      end
    end

    // Soft reset held 3 edges: hold count must not start until it drops
    sw = 1'b1;
    tick; // 341
    chk("sw_ch", ch_a, 4'hF);
    chk("sw_done", done_a, 0);
    chk("sw_state", st_a, 0);
    chk("sw_wdog_clr", to_a, 0);
    tick; tick; // 343
    sw = 1'b0;
    while (e < 367) tick;
    chk("sw_e367", ch_a, 4'hF);
    tick; chk("sw_e368", ch_a, 4'hE);
    tick; // 369, mid-RELEASE

    // Asynchronous reset between edges
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ch", ch_a, 4'hF);
    chk("arst_done", done_a, 0);
    chk("arst_state", st_a, 0);
    chk("arst_ch_c", ch_c, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;

    // Soft reset pulse between edges 28 and 29
    while (e < 25) tick;
    chk("p_e25", ch_a, 4'hE);
    while (e < 28) tick;
    chk("p_e28", ch_a, 4'hC);
    sw = 1'b1;
    tick; // 29
    sw = 1'b0;
    chk("p_e29_ch", ch_a, 4'hF);
    chk("p_e29_done", done_a, 0);
    while (e < 53) tick;
    chk("p_e53", ch_a, 4'hF);
    tick; chk("p_e54", ch_a, 4'hE);
    tick; tick; chk("p_e56", ch_a, 4'hC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
